ac_motor_sine_ramp: RTL and testbench

Parametrised N-phase sine reference for the AC motor drive, and the next generation of the three-phase sine generator. It adds slew-limited frequency and amplitude ramping, latched parameter updates via `lock`, and safe direction reversal through zero speed. It produces the per-phase signed modulation references consumed by the PWM/triangle comparator stage.

---
 rtl/ac_motor_sine_ramp.sv | 172 +++++++++++++++++
 tb/tb_ac_motor_sine_ramp.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_sine_ramp.sv
// N-phase sine modulation reference with slew-limited frequency/amplitude
// ramping, latched targets and direction reversal through zero speed.
module ac_motor_sine_ramp #(
    parameter int unsigned FREQ_W   = 12,
    parameter int unsigned AMP_W    = 12,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned LUT_AW   = 8,
    parameter int unsigned SINE_W   = 12,
    parameter int unsigned PHASES   = 3,
    parameter int unsigned RAMP_DIV = 16,
    localparam int unsigned OUT_W   = AMP_W + SINE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FREQ_W-1:0]         frequency,
    input  logic signed [AMP_W-1:0]   amplitude,
    input  logic                      reverse,
    input  logic                      lock,
    output logic [PHASES*OUT_W-1:0]   sine,
    output logic                      out_valid,
    output logic                      at_target
);

    localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned LUT_N = 2 ** LUT_AW;
    localparam longint unsigned PHASE_STEP = (64'd1 << ACC_W) / PHASES;
    localparam real HALF_PI = 1.5707963267948966;

    typedef enum logic {RUN, DECEL} state_t;

    state_t                    state, state_nxt;
    logic [FREQ_W-1:0]         freq_tgt, freq_cur, freq_nxt;
    logic signed [AMP_W-1:0]   amp_tgt, amp_cur, amp_d;
    logic                      dir_tgt, dir, dir_nxt;
    logic [CNT_W-1:0]          ramp_cnt;
    logic                      tick;
    logic [ACC_W-1:0]          acc;
    logic [2:0]                vld_sr;
    logic [SINE_W-1:0]         lut [LUT_N];

    // Quarter-wave table entry, rounded to nearest, sampled at bin centres
    function automatic logic [SINE_W-1:0] lut_entry(input int i);
        real x;
        x = real'((64'd1 << SINE_W) - 64'd1)
            * $sin(HALF_PI * (real'(i) + 0.5) / real'(LUT_N));
        return SINE_W'($rtoi(x + 0.5));
    endfunction

    for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        assign lut[i] = lut_entry(i);
    end

    assign tick = (ramp_cnt == CNT_W'(RAMP_DIV - 1));

    // Target latches and free-running ramp divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_tgt <= '0;
            amp_tgt  <= '0;
            dir_tgt  <= 1'b0;
            ramp_cnt <= '0;
        end else begin
            if (lock) begin
                freq_tgt <= frequency;
                amp_tgt  <= amplitude;
                dir_tgt  <= reverse;
            end
            ramp_cnt <= tick ? '0 : ramp_cnt + CNT_W'(1);
        end
    end

    // Direction FSM state register with ramped frequency and direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            freq_cur <= '0;
            dir      <= 1'b0;
        end else begin
            state    <= state_nxt;
            freq_cur <= freq_nxt;
            dir      <= dir_nxt;
        end
    end

    // Next-state: slew toward target in RUN, coast to zero before flipping dir
    always_comb begin
        state_nxt = state;
        freq_nxt  = freq_cur;
        dir_nxt   = dir;
        unique case (state)
            RUN: begin
                if (tick) begin
                    if (freq_cur < freq_tgt)
                        freq_nxt = freq_cur + FREQ_W'(1);
                    else if (freq_cur > freq_tgt)
                        freq_nxt = freq_cur - FREQ_W'(1);
                end
                if (dir_tgt != dir)
                    state_nxt = DECEL;
            end
            DECEL: begin
                if (dir_tgt == dir) begin
                    state_nxt = RUN;
                end else if (tick) begin
                    if (freq_cur == '0) begin
                        dir_nxt   = dir_tgt;
                        state_nxt = RUN;
                    end else begin
                        freq_nxt = freq_cur - FREQ_W'(1);
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Amplitude slew, phase accumulator and pipeline-primed shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp_cur <= '0;
            amp_d   <= '0;
            acc     <= '0;
            vld_sr  <= '0;
        end else begin
            if (tick) begin
                if (amp_cur < amp_tgt)
                    amp_cur <= amp_cur + AMP_W'(1);
                else if (amp_cur > amp_tgt)
                    amp_cur <= amp_cur - AMP_W'(1);
            end
            amp_d  <= amp_cur;
            acc    <= dir ? acc - ACC_W'(freq_cur) : acc + ACC_W'(freq_cur);
            vld_sr <= {vld_sr[1:0], 1'b1};
        end
    end

    assign out_valid = vld_sr[2];
    assign at_target = (freq_cur == freq_tgt) && (amp_cur == amp_tgt)
                     && (dir == dir_tgt) && (state == RUN);

    for (genvar k = 0; k < PHASES; k++) begin : g_ph
        localparam logic [ACC_W-1:0] PH_OFS = ACC_W'(PHASE_STEP * k);

        logic [LUT_AW+1:0]         top;
        logic [LUT_AW-1:0]         idx;
        logic [SINE_W-1:0]         mag;
        logic signed [SINE_W:0]    samp_nxt, samp_q;
        logic signed [OUT_W-1:0]   a_x, s_x, prod, sine_q;

        assign top      = (LUT_AW+2)'((acc + PH_OFS) >> (ACC_W - LUT_AW - 2));
        assign idx      = top[LUT_AW] ? ~top[LUT_AW-1:0] : top[LUT_AW-1:0];
        assign mag      = lut[idx];
        assign samp_nxt = top[LUT_AW+1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        assign a_x      = {{(OUT_W-AMP_W){amp_d[AMP_W-1]}}, amp_d};
        assign s_x      = {{(OUT_W-SINE_W-1){samp_q[SINE_W]}}, samp_q};
        assign prod     = a_x * s_x;

        // Sample stage then product stage for this phase
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                samp_q <= '0;
                sine_q <= '0;
            end else begin
                samp_q <= samp_nxt;
                sine_q <= prod;
            end
        end

        assign sine[k*OUT_W +: OUT_W] = sine_q;
    end

endmodule

// File: tb/tb_ac_motor_sine_ramp.sv
// Directed bench for ac_motor_sine_ramp with RAMP_DIV=4.
module tb_ac_motor_sine_ramp;

    localparam int unsigned OUT_W  = 24;
    localparam int unsigned PHASES = 3;

    logic                       clk;
    logic                       rst_n;
    logic [11:0]                frequency;
    logic signed [11:0]         amplitude;
    logic                       reverse;
    logic                       lock;
    logic [PHASES*OUT_W-1:0]    sine;
    logic                       out_valid;
    logic                       at_target;

    int total;
    int bad;

    ac_motor_sine_ramp #(.RAMP_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frequency (frequency),
        .amplitude (amplitude),
        .reverse   (reverse),
        .lock      (lock),
        .sine      (sine),
        .out_valid (out_valid),
        .at_target (at_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int f, input int a, input logic r);
        frequency = 12'(f);
        amplitude = 12'(a);
        reverse   = r;
        lock      = 1'b1;
        step(1);
        lock      = 1'b0;
    endtask

    function automatic longint ph(input int k);
        logic signed [OUT_W-1:0] v;
        v = sine[k*OUT_W +: OUT_W];
        return longint'(v);
    endfunction

    task automatic wait_target(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (at_target) break;
            step(1);
        end
        check(tag, longint'(at_target), 1);
    endtask

    // Observe one-plus periods at full speed: peaks, balance and phase order
    task automatic measure(input string pfx, input int lag_lo, input int lag_hi);
        longint p0, p1, p2, s, mx, mn, worst, prev0, prev1;
        int t0, lag;
        mx = 0; mn = 0; worst = 0; t0 = -1; lag = -1;
        prev0 = ph(0);
        prev1 = ph(1);
        for (int i = 1; i < 7200; i++) begin
            step(1);
            p0 = ph(0); p1 = ph(1); p2 = ph(2);
            if (p0 > mx) mx = p0;
            if (p0 < mn) mn = p0;
            s = p0 + p1 + p2;
            if (s < 0) s = -s;
            if (s > worst) worst = s;
            if (t0 < 0 && prev0 < 0 && p0 >= 0)
                t0 = i;
            else if (t0 >= 0 && lag < 0 && prev1 < 0 && p1 >= 0)
                lag = i - t0;
            prev0 = p0;
            prev1 = p1;
        end
        check({pfx, "_peak"}, mx, 8382465);
        check({pfx, "_trough"}, mn, -8382465);
        check($sformatf("%s_sum_%0d_le_196512", pfx, worst), longint'(worst <= 196512), 1);
        check($sformatf("%s_p1_after_p0_%0d_in_%0d_%0d", pfx, lag, lag_lo, lag_hi),
              longint'(lag >= lag_lo && lag <= lag_hi), 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        lock  = 1'b0;
        reverse   = 1'b0;
        frequency = '0;
        amplitude = '0;

        // Reset state
        step(3);
        check("rst_sine0", ph(0), 0);
        check("rst_sine2", ph(2), 0);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_at_target", longint'(at_target), 1);

        // Release, then lock 100/1000 on the first edge
        rst_n = 1'b1;
        load(100, 1000, 1'b0);                       // edge 1
        check("valid_e1", longint'(out_valid), 0);
        check("at_target_e1", longint'(at_target), 0);
        step(1);                                     // edge 2
        check("valid_e2", longint'(out_valid), 0);
        step(1);                                     // edge 3
        check("valid_e3", longint'(out_valid), 1);

        // Ramp: tick every 4th edge
        step(396);                                   // edge 399
        check("ramp_f399", longint'(dut.freq_cur), 99);
        step(1);                                     // edge 400
        check("ramp_f400", longint'(dut.freq_cur), 100);
        check("ramp_a400", longint'(dut.amp_cur), 100);
        check("ramp_tgt400", longint'(at_target), 0);
        step(3599);                                  // edge 3999
        check("ramp_a3999", longint'(dut.amp_cur), 999);
        check("ramp_tgt3999", longint'(at_target), 0);
        step(1);                                     // edge 4000
        check("ramp_a4000", longint'(dut.amp_cur), 1000);
        check("ramp_tgt4000", longint'(at_target), 1);

        // Cancel: start reversal, revoke it at freq 50
        load(100, 1000, 1'b1);                       // edge 4001
        check("cancel_tgt_drop", longint'(at_target), 0);
        step(199);                                   // edge 4200
        check("cancel_f50", longint'(dut.freq_cur), 50);
        check("cancel_dir_pre", longint'(dut.dir), 0);
        load(100, 1000, 1'b0);                       // edge 4201
        check("cancel_hold", longint'(dut.freq_cur), 50);
        step(3);                                     // edge 4204
        check("cancel_f51", longint'(dut.freq_cur), 51);
        step(195);                                   // edge 4399
        check("cancel_f99", longint'(dut.freq_cur), 99);
        check("cancel_tgt4399", longint'(at_target), 0);
        step(1);                                     // edge 4400
        check("cancel_f100", longint'(dut.freq_cur), 100);
        check("cancel_tgt4400", longint'(at_target), 1);
        check("cancel_dir", longint'(dut.dir), 0);

        // Reversal through zero speed
        load(100, 1000, 1'b1);                       // edge 4401
        check("rev_tgt_drop", longint'(at_target), 0);
        step(399);                                   // edge 4800
        check("rev_f0", longint'(dut.freq_cur), 0);
        check("rev_dir_hold", longint'(dut.dir), 0);
        check("rev_tgt_mid", longint'(at_target), 0);
        step(4);                                     // edge 4804
        check("rev_dir_flip", longint'(dut.dir), 1);
        check("rev_f0_flip", longint'(dut.freq_cur), 0);
        step(399);                                   // edge 5203
        check("rev_f99", longint'(dut.freq_cur), 99);
        check("rev_tgt5203", longint'(at_target), 0);
        step(1);                                     // edge 5204
        check("rev_f100", longint'(dut.freq_cur), 100);
        check("rev_tgt5204", longint'(at_target), 1);

        // Full-scale waveform, reverse direction first
        load(4095, 2047, 1'b1);
        wait_target("wave_rev_reached", 17000);
        measure("rev", 1362, 1369);

        // Full-scale waveform after reversal to forward
        load(4095, 2047, 1'b0);
        wait_target("wave_fwd_reached", 34000);
        check("wave_fwd_dir", longint'(dut.dir), 0);
        measure("fwd", 2728, 2735);

        // Asynchronous reset between edges
        check("arst_pre_valid", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", longint'(out_valid), 0);
        check("arst_sine0", ph(0), 0);
        check("arst_sine1", ph(1), 0);
        check("arst_sine2", ph(2), 0);
        check("arst_at_target", longint'(at_target), 1);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
